// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: decodes the D-stage instruction once and carries its control word through E/M/W,
// with bubble insertion on stall and a multiply/divide busy counter that raises its own stall.
module pipeline_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_d,
    input  logic        stall,
    output logic [1:0]  npc_sel_d,
    output logic        cmp_op_d,
    output logic [1:0]  ext_op_d,
    output logic        md_stall_d,
    output logic        alu_src_e,
    output logic [2:0]  alu_op_e,
    output logic [2:0]  md_op_e,
    output logic        md_start_e,
    output logic        md_busy,
    output logic        mem_write_m,
    output logic        reg_write_w,
    output logic [1:0]  wd_sel_w,
    output logic        hilo_sel_w,
    output logic [4:0]  a3_e,
    output logic [4:0]  a3_m,
    output logic [4:0]  a3_w,
    output logic [1:0]  tnew_e,
    output logic [1:0]  tnew_m
);
    localparam int CW = $clog2(DIV_CYCLES + 1);

    typedef struct packed {
        logic       alu_src;
        logic [2:0] alu_op;
        logic [2:0] md_op;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] wd_sel;
        logic       hilo_sel;
        logic [4:0] a3;
        logic [1:0] tnew;
    } ectrl_t;

    typedef struct packed {
        logic       mem_write;
        logic       reg_write;
        logic [1:0] wd_sel;
        logic       hilo_sel;
        logic [4:0] a3;
        logic [1:0] tnew;
    } mctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] wd_sel;
        logic       hilo_sel;
        logic [4:0] a3;
    } wctrl_t;

    logic [5:0] op, fn;
    logic [4:0] rt, rd, a3_raw;
    logic       r, addu_i, subu_i, sra_i, jr_i, jalr_i, mult_i, multu_i, div_i, divu_i;
    logic       mfhi_i, mflo_i, mthi_i, mtlo_i, ori_i, lui_i, addi_i, lw_i, sw_i;
    logic       beq_i, bgez_i, j_i, jal_i, md_class, unused_bits;
    ectrl_t     d, e;
    mctrl_t     m;
    wctrl_t     w;
    logic [CW-1:0] cnt;

    assign op = instr_d[31:26];
    assign rt = instr_d[20:16];
    assign rd = instr_d[15:11];
    assign fn = instr_d[5:0];
    assign unused_bits = ^{instr_d[25:21], instr_d[10:6]};

    assign r       = op == 6'h00;
    assign addu_i  = r && fn == 6'h21;
    assign subu_i  = r && fn == 6'h23;
    assign sra_i   = r && fn == 6'h03;
    assign jr_i    = r && fn == 6'h08;
    assign jalr_i  = r && fn == 6'h09;
    assign mfhi_i  = r && fn == 6'h10;
    assign mthi_i  = r && fn == 6'h11;
    assign mflo_i  = r && fn == 6'h12;
    assign mtlo_i  = r && fn == 6'h13;
    assign mult_i  = r && fn == 6'h18;
    assign multu_i = r && fn == 6'h19;
    assign div_i   = r && fn == 6'h1A;
    assign divu_i  = r && fn == 6'h1B;
    assign ori_i   = op == 6'h0D;
    assign lui_i   = op == 6'h0F;
    assign addi_i  = op == 6'h08;
    assign lw_i    = op == 6'h23;
    assign sw_i    = op == 6'h2B;
    assign beq_i   = op == 6'h04;
    assign bgez_i  = op == 6'h01 && rt == 5'd1;
    assign j_i     = op == 6'h02;
    assign jal_i   = op == 6'h03;
    assign md_class = mult_i | multu_i | div_i | divu_i | mfhi_i | mflo_i | mthi_i | mtlo_i;

    // a write to $0 is no write at all, so the hazard unit never sees it as a producer
    assign a3_raw = (addu_i | subu_i | sra_i | jalr_i | mfhi_i | mflo_i) ? rd :
                    (ori_i | lui_i | addi_i | lw_i) ? rt : jal_i ? 5'd31 : 5'd0;

    always_comb begin
        d           = '0;
        d.alu_src   = ori_i | lui_i | addi_i | lw_i | sw_i;
        d.alu_op    = subu_i ? 3'd1 : ori_i ? 3'd2 : sra_i ? 3'd3 : 3'd0;
        d.md_op     = mult_i ? 3'd1 : multu_i ? 3'd2 : div_i ? 3'd3 : divu_i ? 3'd4 :
                      mthi_i ? 3'd5 : mtlo_i ? 3'd6 : 3'd0;
        d.mem_write = sw_i;
        d.reg_write = a3_raw != 5'd0;
        d.wd_sel    = lw_i ? 2'd1 : (jal_i | jalr_i) ? 2'd2 : (mfhi_i | mflo_i) ? 2'd3 : 2'd0;
        d.hilo_sel  = mfhi_i;
        d.a3        = a3_raw;
        d.tnew      = lw_i ? 2'd2 :
                      (addu_i | subu_i | sra_i | ori_i | lui_i | addi_i | mfhi_i | mflo_i) ? 2'd1 : 2'd0;
    end

    assign npc_sel_d  = (beq_i | bgez_i) ? 2'd1 : (j_i | jal_i) ? 2'd2 : (jr_i | jalr_i) ? 2'd3 : 2'd0;
    assign cmp_op_d   = bgez_i;
    assign ext_op_d   = (lw_i | sw_i | addi_i) ? 2'd1 : lui_i ? 2'd2 : 2'd0;
    assign md_start_e = e.md_op != 3'd0 && e.md_op <= 3'd4;
    assign md_busy    = cnt != '0;
    assign md_stall_d = md_class & (md_start_e | md_busy);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e   <= '0;
            m   <= '0;
            w   <= '0;
            cnt <= '0;
        end else begin
            e   <= stall ? '0 : d;
            m   <= '{e.mem_write, e.reg_write, e.wd_sel, e.hilo_sel, e.a3, e.tnew - 2'(e.tnew != 2'd0)};
            w   <= '{m.reg_write, m.wd_sel, m.hilo_sel, m.a3};
            cnt <= md_start_e ? ((e.md_op <= 3'd2) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES)) :
                   cnt - CW'(md_busy);
        end
    end

    assign alu_src_e   = e.alu_src;
    assign alu_op_e    = e.alu_op;
    assign md_op_e     = e.md_op;
    assign a3_e        = e.a3;
    assign tnew_e      = e.tnew;
    assign mem_write_m = m.mem_write;
    assign a3_m        = m.a3;
    assign tnew_m      = m.tnew;
    assign reg_write_w = w.reg_write;
    assign wd_sel_w    = w.wd_sel;
    assign hilo_sel_w  = w.hilo_sel;
    assign a3_w        = w.a3;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed decode vectors walked through D/E/M/W, plus stall, md-busy and reset sequences.
module tb_pipeline_ctrl;
    logic        clk = 1'b0, reset = 1'b0, hz_stall = 1'b0, stall;
    logic [31:0] instr_d = '0;
    logic [1:0]  npc_sel_d, ext_op_d, wd_sel_w, tnew_e, tnew_m;
    logic        cmp_op_d, md_stall_d, alu_src_e, md_start_e, md_busy, mem_write_m, reg_write_w, hilo_sel_w;
    logic [2:0]  alu_op_e, md_op_e;
    logic [4:0]  a3_e, a3_m, a3_w;
    logic [32:0] regs_all;
    int          pass = 0, total = 0;

    assign stall = hz_stall | md_stall_d;
    assign regs_all = {alu_src_e, alu_op_e, md_op_e, md_start_e, md_busy, mem_write_m, reg_write_w,
                       wd_sel_w, hilo_sel_w, a3_e, a3_m, a3_w, tnew_e, tnew_m};

    pipeline_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .instr_d(instr_d), .stall(stall),
        .npc_sel_d(npc_sel_d), .cmp_op_d(cmp_op_d), .ext_op_d(ext_op_d), .md_stall_d(md_stall_d),
        .alu_src_e(alu_src_e), .alu_op_e(alu_op_e), .md_op_e(md_op_e), .md_start_e(md_start_e),
        .md_busy(md_busy), .mem_write_m(mem_write_m), .reg_write_w(reg_write_w), .wd_sel_w(wd_sel_w),
        .hilo_sel_w(hilo_sel_w), .a3_e(a3_e), .a3_m(a3_m), .a3_w(a3_w), .tnew_e(tnew_e), .tnew_m(tnew_m)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  npc;
        logic        cmp;
        logic [1:0]  ext;
        logic        src;
        logic [2:0]  aop;
        logic [2:0]  mop;
        logic [4:0]  a3;
        logic [1:0]  te;
        logic [1:0]  tm;
        logic        mw;
        logic        rw;
        logic [1:0]  wd;
        logic        hs;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic md_seq(input string nm, input logic [31:0] ins, input logic [2:0] mop, input int exp_n);
        int n = 0;
        @(negedge clk) instr_d = ins;
        @(negedge clk);
        chk({nm, " start"}, {md_start_e, md_op_e, md_busy}, {1'b1, mop, 1'b0});
        instr_d = 32'h00005812;
        #1;
        while (md_stall_d && n < 40) begin
            n++;
            @(negedge clk);
            #1;
            if (n == 1) chk({nm, " busy"}, {md_start_e, md_busy}, 2'b01);
        end
        chk({nm, " stall cycles"}, 64'(n), 64'(exp_n));
        @(negedge clk) instr_d = '0;
        chk({nm, " mflo E"}, {md_start_e, md_op_e, md_busy, a3_e, tnew_e}, {1'b0, 3'd0, 1'b0, 5'd11, 2'd1});
        @(negedge clk);
        @(negedge clk);
        chk({nm, " mflo W"}, {reg_write_w, wd_sel_w, hilo_sel_w, a3_w}, {1'b1, 2'd3, 1'b0, 5'd11});
    endtask

    initial begin
        vecs[0]  = '{32'h00221821, 2'd0, 1'b0, 2'd0, 1'b0, 3'd0, 3'd0, 5'd3,  2'd1, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0};
        vecs[1]  = '{32'h8C050004, 2'd0, 1'b0, 2'd1, 1'b1, 3'd0, 3'd0, 5'd5,  2'd2, 2'd1, 1'b0, 1'b1, 2'd1, 1'b0};
        vecs[2]  = '{32'hAC050008, 2'd0, 1'b0, 2'd1, 1'b1, 3'd0, 3'd0, 5'd0,  2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[3]  = '{32'h342400FF, 2'd0, 1'b0, 2'd0, 1'b1, 3'd2, 3'd0, 5'd4,  2'd1, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0};
        vecs[4]  = '{32'h3C061234, 2'd0, 1'b0, 2'd2, 1'b1, 3'd0, 3'd0, 5'd6,  2'd1, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0};
        vecs[5]  = '{32'h00223823, 2'd0, 1'b0, 2'd0, 1'b0, 3'd1, 3'd0, 5'd7,  2'd1, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0};
        vecs[6]  = '{32'h000240C3, 2'd0, 1'b0, 2'd0, 1'b0, 3'd3, 3'd0, 5'd8,  2'd1, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0};
        vecs[7]  = '{32'h2029FFFF, 2'd0, 1'b0, 2'd1, 1'b1, 3'd0, 3'd0, 5'd9,  2'd1, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0};
        vecs[8]  = '{32'h10220003, 2'd1, 1'b0, 2'd0, 1'b0, 3'd0, 3'd0, 5'd0,  2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[9]  = '{32'h04210003, 2'd1, 1'b1, 2'd0, 1'b0, 3'd0, 3'd0, 5'd0,  2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[10] = '{32'h08000010, 2'd2, 1'b0, 2'd0, 1'b0, 3'd0, 3'd0, 5'd0,  2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[11] = '{32'h0C000010, 2'd2, 1'b0, 2'd0, 1'b0, 3'd0, 3'd0, 5'd31, 2'd0, 2'd0, 1'b0, 1'b1, 2'd2, 1'b0};
        vecs[12] = '{32'h03E00008, 2'd3, 1'b0, 2'd0, 1'b0, 3'd0, 3'd0, 5'd0,  2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[13] = '{32'h00200009, 2'd3, 1'b0, 2'd0, 1'b0, 3'd0, 3'd0, 5'd0,  2'd0, 2'd0, 1'b0, 1'b0, 2'd2, 1'b0};
        vecs[14] = '{32'h0020F809, 2'd3, 1'b0, 2'd0, 1'b0, 3'd0, 3'd0, 5'd31, 2'd0, 2'd0, 1'b0, 1'b1, 2'd2, 1'b0};
        vecs[15] = '{32'h00005010, 2'd0, 1'b0, 2'd0, 1'b0, 3'd0, 3'd0, 5'd10, 2'd1, 2'd0, 1'b0, 1'b1, 2'd3, 1'b1};
        vecs[16] = '{32'h00005812, 2'd0, 1'b0, 2'd0, 1'b0, 3'd0, 3'd0, 5'd11, 2'd1, 2'd0, 1'b0, 1'b1, 2'd3, 1'b0};
        vecs[17] = '{32'h00200011, 2'd0, 1'b0, 2'd0, 1'b0, 3'd0, 3'd5, 5'd0,  2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[18] = '{32'h00200013, 2'd0, 1'b0, 2'd0, 1'b0, 3'd0, 3'd6, 5'd0,  2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[19] = '{32'hFC000000, 2'd0, 1'b0, 2'd0, 1'b0, 3'd0, 3'd0, 5'd0,  2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0};

        #1 chk("reset regs", 64'(regs_all), 64'd0);
        @(negedge clk) reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk) instr_d = vecs[i].instr;
            #1 chk($sformatf("v%0d D", i), {npc_sel_d, cmp_op_d, ext_op_d, md_stall_d},
                   {vecs[i].npc, vecs[i].cmp, vecs[i].ext, 1'b0});
            @(negedge clk) instr_d = '0;
            chk($sformatf("v%0d E", i), {alu_src_e, alu_op_e, md_op_e, md_start_e, a3_e, tnew_e},
                {vecs[i].src, vecs[i].aop, vecs[i].mop, 1'b0, vecs[i].a3, vecs[i].te});
            @(negedge clk);
            chk($sformatf("v%0d M", i), {mem_write_m, a3_m, tnew_m}, {vecs[i].mw, vecs[i].a3, vecs[i].tm});
            @(negedge clk);
            chk($sformatf("v%0d W", i), {reg_write_w, wd_sel_w, hilo_sel_w, a3_w},
                {vecs[i].rw, vecs[i].wd, vecs[i].hs, vecs[i].a3});
        end

        // ori held in D under an external stall: two bubbles, then it issues
        @(negedge clk) begin instr_d = 32'h342400FF; hz_stall = 1'b1; end
        @(negedge clk) chk("stall bubble 1", 64'(regs_all), 64'd0);
        @(negedge clk) chk("stall bubble 2", 64'(regs_all), 64'd0);
        hz_stall = 1'b0;
        @(negedge clk) instr_d = '0;
        chk("stall release", {alu_src_e, alu_op_e, a3_e, tnew_e}, {1'b1, 3'd2, 5'd4, 2'd1});

        md_seq("mult", 32'h00220018, 3'd1, 6);
        md_seq("div", 32'h0022001A, 3'd3, 11);

        // asynchronous reset with a live pipeline
        @(negedge clk) instr_d = 32'h8C050004;
        @(negedge clk) instr_d = 32'h00221821;
        @(negedge clk) instr_d = '0;
        chk("pre-reset", {a3_e, a3_m, tnew_m}, {5'd3, 5'd5, 2'd1});
        #2 reset = 1'b0;
        #1 chk("async reset", 64'(regs_all), 64'd0);
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 3; i++) @(negedge clk) chk($sformatf("nop after reset %0d", i), 64'(regs_all), 64'd0);

        // reset abandons a running busy count
        @(negedge clk) instr_d = 32'h00220018;
        @(negedge clk) instr_d = '0;
        @(negedge clk) chk("busy before reset", 64'(md_busy), 64'd1);
        #2 reset = 1'b0;
        #1 chk("busy cleared", 64'(md_busy), 64'd0);
        @(negedge clk) begin reset = 1'b1; instr_d = 32'h00005812; end
        #1 chk("no md stall after reset", 64'(md_stall_d), 64'd0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
